mac_delay_unit: RTL and testbench

- One processing element of the streaming convolution array.
- A signed N-bit multiply-accumulate cell with a registered 32-bit output (transposed-form partial sum), followed by a data-enabled delay line of DEPTH samples.
- The delay line carries a row-end partial sum across the remaining (INPUT_SIZE-KERNEL_SIZE) pixels of the image row.
- Instantiated KERNEL_SIZE*KERNEL_SIZE times inside the conv unit; only row-end cells use the delay output.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/line_delay_reg.sv | 51 +++++
 rtl/mac_delay_unit.sv | 66 ++++++
 tb/tb_mac_delay_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the streaming convolution array: partial-sum width,
// signed accumulator type and the saturating add used when the MAC_SAT_EN
// build macro is defined.
package conv_pkg;

    localparam int ACC_W = 32;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Signed add that clamps to the accumulator range instead of wrapping.
    // Overflow is only possible when both operands share a sign and the
    // wrapped sum does not.
    function automatic acc_t sat_add(acc_t a, acc_t b);
        acc_t sum;
        sum = a + b;
        if ((a[ACC_W-1] == b[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]))
            return a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        return sum;
    endfunction

endpackage

// File: rtl/line_delay_reg.sv
// Data-enabled delay line: shifts only on input_vld, so gaps in the sample
// stream never advance data. The fill counter gates dout_vld until depth
// samples are inside the line. depth = 0 degenerates to a wire.
module line_delay_reg #(
    parameter int width = 32,
    parameter int depth = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             input_vld,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             dout_vld
);

    generate
        if (depth == 0) begin : g_pass
            assign dout     = din;
            assign dout_vld = input_vld;
        end else begin : g_line
            localparam int CW = $clog2(depth + 1);
            localparam logic [CW-1:0] FULL = CW'(depth);

            logic [width-1:0] mem [depth];
            logic [CW-1:0]    fill;

            // Shift register, advanced only by valid samples.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < depth; i++) mem[i] <= '0;
                end else if (input_vld) begin
                    mem[0] <= din;
                    for (int i = 1; i < depth; i++) mem[i] <= mem[i-1];
                end
            end

            // Count shifts up to depth; once full the line output is meaningful.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fill <= '0;
                end else if (input_vld && (fill != FULL)) begin
                    fill <= fill + 1'b1;
                end
            end

            assign dout     = mem[depth-1];
            assign dout_vld = input_vld && (fill == FULL);
        end
    endgenerate

endmodule

// File: rtl/mac_delay_unit.sv
// One processing element of the streaming convolution array: a signed
// multiply-accumulate with a registered partial-sum output, followed by a
// data-enabled delay line that carries row-end partial sums across the rest
// of the image row.
// Build option: define MAC_SAT_EN to saturate the accumulate to the signed
// ACC_W range; otherwise the add wraps modulo 2^ACC_W.
module mac_delay_unit
    import conv_pkg::*;
#(
    parameter int N     = 8,
    parameter int ACC_W = conv_pkg::ACC_W,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             multiplicand_vld,
    input  logic             addend_vld,
    input  logic [N-1:0]     multiplicand_din,
    input  logic [N-1:0]     multiplier_din,
    input  logic [ACC_W-1:0] addend_din,
    output logic [ACC_W-1:0] mac_dout,
    output logic             mac_dout_vld,
    output logic [ACC_W-1:0] dly_dout,
    output logic             dly_dout_vld
);

    logic signed [2*N-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] mac_next;
    logic                    mac_en;

    assign mac_en   = multiplicand_vld && addend_vld;
    assign prod     = $signed(multiplicand_din) * $signed(multiplier_din);
    assign prod_ext = {{(ACC_W-2*N){prod[2*N-1]}}, prod};

    // Accumulate: product plus incoming partial sum, wrapped or clamped.
`ifdef MAC_SAT_EN
    assign mac_next = ACC_W'(sat_add(acc_t'(prod_ext), acc_t'($signed(addend_din))));
`else
    assign mac_next = prod_ext + $signed(addend_din);
`endif

    // Registered MAC output; value holds whenever the operand pair is incomplete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_dout     <= '0;
            mac_dout_vld <= 1'b0;
        end else begin
            mac_dout_vld <= mac_en;
            if (mac_en) mac_dout <= mac_next;
        end
    end

    line_delay_reg #(
        .width (ACC_W),
        .depth (DEPTH)
    ) u_line_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .input_vld (mac_dout_vld),
        .din       (mac_dout),
        .dout      (dly_dout),
        .dout_vld  (dly_dout_vld)
    );

endmodule

// File: tb/tb_mac_delay_unit.sv
module tb_mac_delay_unit;

    localparam int N     = 8;
    localparam int ACC_W = 32;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             multiplicand_vld = 1'b0;
    logic             addend_vld = 1'b0;
    logic [N-1:0]     multiplicand_din = '0;
    logic [N-1:0]     multiplier_din = '0;
    logic [ACC_W-1:0] addend_din = '0;
    logic [ACC_W-1:0] mac_dout;
    logic             mac_dout_vld;
    logic [ACC_W-1:0] dly_dout;
    logic             dly_dout_vld;

    mac_delay_unit #(.N(N), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .multiplicand_vld (multiplicand_vld),
        .addend_vld       (addend_vld),
        .multiplicand_din (multiplicand_din),
        .multiplier_din   (multiplier_din),
        .addend_din       (addend_din),
        .mac_dout         (mac_dout),
        .mac_dout_vld     (mac_dout_vld),
        .dly_dout         (dly_dout),
        .dly_dout_vld     (dly_dout_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mac;
        bit          has_dly;
        logic [31:0] dly;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] hist[$];
    logic [31:0] last_mac = '0;
    bit          running = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Reference arithmetic: exact integer result, then wrap or clamp.
    function automatic logic [31:0] model(int a, int b, int c);
        longint s;
        s = longint'(a) * longint'(b) + longint'(c);
`ifdef MAC_SAT_EN
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        return s[31:0];
    endfunction

    // Drive one cycle of inputs; record the expected response if it fires.
    task automatic drive(bit mv, bit av, int din, int w, int add);
        exp_t e;
        @(posedge clk);
        #1;
        multiplicand_vld = mv;
        addend_vld       = av;
        multiplicand_din = N'(din);
        multiplier_din   = N'(w);
        addend_din       = ACC_W'(add);
        if (mv && av) begin
            e.mac = model(din, w, add);
            hist.push_back(e.mac);
            e.has_dly = (hist.size() > DEPTH);
            e.dly     = e.has_dly ? hist[hist.size()-1-DEPTH] : '0;
            sbq.push_back(e);
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    // Mid-cycle asynchronous reset; outputs must clear without a clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        multiplicand_vld = 1'b0;
        addend_vld = 1'b0;
        sbq.delete();
        hist.delete();
        last_mac = '0;
        #1;
        chk("rst_mac_dout", mac_dout, 32'h0);
        chk("rst_mac_vld", 32'(mac_dout_vld), 32'h0);
        chk("rst_dly_dout", dly_dout, 32'h0);
        chk("rst_dly_vld", 32'(dly_dout_vld), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a MAC result.
    always @(negedge clk) begin
        if (running) begin
            if (mac_dout_vld) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_mac_vld", 32'(mac_dout_vld), 32'h0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("mac_dout", mac_dout, e.mac);
                    chk("dly_vld", 32'(dly_dout_vld), 32'(e.has_dly));
                    if (e.has_dly) chk("dly_dout", dly_dout, e.dly);
                    last_mac = e.mac;
                end
            end else begin
                chk("mac_hold", mac_dout, last_mac);
                chk("dly_vld_idle", 32'(dly_dout_vld), 32'h0);
            end
        end
    end

    initial begin
        do_reset();
        running = 1'b1;

        // Basic MAC and hold
        drive(1, 1, 5, -3, 100);
        idle();
        @(negedge clk);
        chk("basic_85", mac_dout, 32'd85);
        chk("basic_vld", 32'(mac_dout_vld), 32'h1);
        idle();
        @(negedge clk);
        chk("basic_vld_drop", 32'(mac_dout_vld), 32'h0);
        chk("basic_held", mac_dout, 32'd85);

        // Sign extremes
        drive(1, 1, -128, -128, 0);
        drive(1, 1, 127, -128, -5);
        idle();
        @(negedge clk);
        chk("ext_neg", mac_dout, 32'hFFFF_C07B);

        // Valid gating: multiplicand without addend
        drive(1, 0, 7, 7, 1000);
        idle();
        @(negedge clk);
        chk("gate_vld", 32'(mac_dout_vld), 32'h0);
        chk("gate_hold", mac_dout, 32'hFFFF_C07B);

        // Delay line with gapped stream
        do_reset();
        drive(1, 1, 0, 0, 10); idle();
        drive(1, 1, 0, 0, 20); idle();
        drive(1, 1, 0, 0, 30); idle();
        @(negedge clk);
        chk("dly_not_yet", 32'(dly_dout_vld), 32'h0);
        drive(1, 1, 0, 0, 40); idle();
        @(negedge clk);
        chk("dly_first_vld", 32'(dly_dout_vld), 32'h1);
        chk("dly_first_10", dly_dout, 32'd10);
        idle();
        @(negedge clk);
        chk("dly_gap_hold", dly_dout, 32'd20);
        drive(1, 1, 0, 0, 50); idle();
        @(negedge clk);
        chk("dly_second_20", dly_dout, 32'd20);

        // Overflow
        drive(1, 1, 1, 1, 32'h7FFF_FFFF);
        idle();
        @(negedge clk);
`ifdef MAC_SAT_EN
        chk("ovf", mac_dout, 32'h7FFF_FFFF);
`else
        chk("ovf", mac_dout, 32'h8000_0000);
`endif

        // Randomized stream with a mid-stream reset
        for (int i = 0; i < 400; i++) begin
            int w, add;
            if (i == 200) do_reset();
            w = $urandom_range(255);
            case ($urandom_range(3))
                0:       add = 32'h7FFF_FF00 + int'($urandom_range(255));
                1:       add = 32'h8000_0000 + int'($urandom_range(255));
                default: add = int'($urandom);
            endcase
            drive($urandom_range(3) != 0, $urandom_range(3) != 0,
                  int'($signed(8'($urandom_range(255)))), int'($signed(8'(w))), add);
        end
        idle();
        idle();
        idle();
        @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'h0);
        running = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
